// File: rtl/mem_port_arbiter.sv
// Round-robin valid/ready arbiter sharing one synchronous memory among 3 ports.
// Optional LOADER_PRIO_EN: port 2 wins outright whenever the arbiter is unlocked.
module mem_port_arbiter #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [2:0]            req,
  input  logic [2:0]            lock,
  input  logic [2:0]            we,
  input  logic [3*ADDR_W-1:0]   addr,
  input  logic [3*DATA_W-1:0]   wdata,
  output logic [2:0]            gnt,
  output logic [2:0]            rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [1:0]            cur_state
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b01,
    ST_LOCKED = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        last_owner_q, last_owner_d;
  logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [2:0]        rd_port_q, rd_port_d;
  logic [2:0]        rvalid_q, rvalid_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

  logic [2:0]        own_oh;
  logic [2:0]        others;
  logic [2:0]        req_arb;
  logic [2:0]        pick;
  logic              locked;
  logic              rel;

  logic [1:0]        win;
  logic              sel_we;
  logic              sel_lock;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // While locked, last_owner_q is the lock owner.
  always_comb begin : arb
    own_oh  = 3'b001 << last_owner_q;
    locked  = (state_q == ST_LOCKED);
    rel     = locked &&
              (!(|(lock & own_oh)) ||
               (lock_cnt_q == CW'(LOCK_MAX)));
    others  = req & ~own_oh;
    req_arb = (rel && (|others)) ? others : req;
    pick    = '0;
`ifdef LOADER_PRIO_EN
    if (req_arb[2]) begin
      pick = 3'b100;
    end else if (last_owner_q == 2'd0) begin
      if (req_arb[1])      pick = 3'b010;
      else if (req_arb[0]) pick = 3'b001;
    end else begin
      if (req_arb[0])      pick = 3'b001;
      else if (req_arb[1]) pick = 3'b010;
    end
`else
    unique case (last_owner_q)
      2'd0: begin
        if (req_arb[1])      pick = 3'b010;
        else if (req_arb[2]) pick = 3'b100;
        else if (req_arb[0]) pick = 3'b001;
      end
      2'd1: begin
        if (req_arb[2])      pick = 3'b100;
        else if (req_arb[0]) pick = 3'b001;
        else if (req_arb[1]) pick = 3'b010;
      end
      default: begin
        if (req_arb[0])      pick = 3'b001;
        else if (req_arb[1]) pick = 3'b010;
        else if (req_arb[2]) pick = 3'b100;
      end
    endcase
`endif
    if (reset)              gnt = '0;
    else if (locked && !rel) gnt = req & own_oh;
    else                    gnt = pick;
  end

  always_comb begin : sel
    win       = last_owner_q;
    sel_we    = 1'b0;
    sel_lock  = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    unique case (1'b1)
      gnt[0]: begin
        win       = 2'd0;
        sel_we    = we[0];
        sel_lock  = lock[0];
        sel_addr  = addr[0 +: ADDR_W];
        sel_wdata = wdata[0 +: DATA_W];
      end
      gnt[1]: begin
        win       = 2'd1;
        sel_we    = we[1];
        sel_lock  = lock[1];
        sel_addr  = addr[ADDR_W +: ADDR_W];
        sel_wdata = wdata[DATA_W +: DATA_W];
      end
      gnt[2]: begin
        win       = 2'd2;
        sel_we    = we[2];
        sel_lock  = lock[2];
        sel_addr  = addr[2*ADDR_W +: ADDR_W];
        sel_wdata = wdata[2*DATA_W +: DATA_W];
      end
      default: ;
    endcase
  end

  always_comb begin : nxt
    state_d      = state_q;
    last_owner_d = last_owner_q;
    lock_cnt_d   = '0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    rd_port_d    = '0;
    rvalid_d     = rd_port_q;
    if (locked) begin
      if (rel) state_d = ST_IDLE;
      else     lock_cnt_d = lock_cnt_q + 1'b1;
    end
    if (|gnt) begin
      last_owner_d = win;
      mem_en_d     = 1'b1;
      mem_we_d     = sel_we;
      mem_addr_d   = sel_addr;
      mem_wdata_d  = sel_wdata;
      rd_port_d    = sel_we ? 3'b000 : gnt;
      // A release cycle arbitrates like idle, so the winner may relock.
      if (sel_lock && (!locked || rel)) begin
        state_d    = ST_LOCKED;
        lock_cnt_d = CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= 2'd2;
      lock_cnt_q   <= '0;
      rd_port_q    <= '0;
      rvalid_q     <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_port_q    <= rd_port_d;
      rvalid_q     <= rvalid_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign rvalid    = rvalid_q;
  assign rdata     = mem_rdata;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cur_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: scenario tasks, read-data scoreboard,
// and a behavioural synchronous memory on the memory side.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, lock, we;
  logic [11:0] addr;
  logic [23:0] wdata;
  logic [2:0]  gnt, rvalid;
  logic [7:0]  rdata;
  logic        mem_en, mem_we;
  logic [3:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;
  logic [1:0]  cur_state;

  mem_port_arbiter #(
    .ADDR_W(4), .DATA_W(8), .LOCK_MAX(4)
  ) dut (
    .clock(clk), .reset(reset),
    .req(req), .lock(lock), .we(we),
    .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .cur_state(cur_state)
  );

  always #5 clk = ~clk;

  int cyc_n = 0;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  logic [7:0] mem [16];
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'h30 + 8'(i);
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct {
    int         due;
    logic [2:0] port;
    logic [7:0] data;
  } sb_t;

  sb_t        sb[$];
  logic [7:0] shadow [16];
  int         tests = 0;
  int         fails = 0;

  task automatic shadow_init();
    for (int i = 0; i < 16; i++) shadow[i] = 8'h30 + 8'(i);
  endtask

  task automatic set_port(input int p, input logic [3:0] a,
                          input logic [7:0] d);
    addr[p*4 +: 4]  = a;
    wdata[p*8 +: 8] = d;
  endtask

  // Commit the expected handshake to the scoreboard, cross the edge,
  // then pop/compare any read data due in the new cycle.
  task automatic advance(input logic [2:0] g);
    int         p;
    logic [3:0] a;
    p = g[0] ? 0 : (g[1] ? 1 : 2);
    if (g != 3'b000) begin
      a = addr[p*4 +: 4];
      if (we[p]) shadow[a] = wdata[p*8 +: 8];
      else       sb.push_back('{cyc_n + 2, g, shadow[a]});
    end
    @(posedge clk);
    #1;
    while (sb.size() > 0 && sb[0].due < cyc_n) begin
      tests++; fails++;
      $display("FAIL sb_missed: port %b never returned", sb[0].port);
      void'(sb.pop_front());
    end
    tests++;
    if (sb.size() > 0 && sb[0].due == cyc_n) begin
      if (rvalid !== sb[0].port || rdata !== sb[0].data) begin
        fails++;
        $display("FAIL sb_read: rvalid %b rdata %h want %b %h",
                 rvalid, rdata, sb[0].port, sb[0].data);
      end
      void'(sb.pop_front());
    end else if (rvalid !== 3'b000) begin
      fails++;
      $display("FAIL sb_spurious: rvalid %b want 000", rvalid);
    end
  endtask

  task automatic idle(input int n);
    req = 3'b000; lock = 3'b000; we = 3'b000;
    for (int i = 0; i < n; i++) begin
      #1;
      tests++;
      if (gnt !== 3'b000) begin
        fails++;
        $display("FAIL idle_gnt: got %b want 000", gnt);
      end
      advance(3'b000);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req = '0; lock = '0; we = '0;
    addr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (cur_state !== 2'b01 || rvalid !== 3'b000) begin
      fails++;
      $display("FAIL rst_state: st %b rv %b want 01 000",
               cur_state, rvalid);
    end
    tests++;
    if (mem_en !== 1'b0 || mem_we !== 1'b0 ||
        mem_addr !== 4'h0 || mem_wdata !== 8'h00) begin
      fails++;
      $display("FAIL rst_mem: en %b we %b a %h d %h want 0 0 0 00",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    req = 3'b111;
    #1;
    tests++;
    if (gnt !== 3'b000) begin
      fails++;
      $display("FAIL rst_gnt: got %b want 000", gnt);
    end
    @(posedge clk);
    #1;
    reset = 1'b0; req = '0;
    sb.delete();
    shadow_init();
  endtask

  task automatic test_rotation();
    logic [2:0] eg [4];
    logic [3:0] ea [4];
    eg = '{3'b001, 3'b010, 3'b100, 3'b001};
    ea = '{4'd1, 4'd2, 4'd3, 4'd1};
    set_port(0, 4'd1, 8'h00);
    set_port(1, 4'd2, 8'h00);
    set_port(2, 4'd3, 8'h00);
    req = 3'b111; we = 3'b000; lock = 3'b000;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests++;
      if (gnt !== eg[i]) begin
        fails++;
        $display("FAIL rot_gnt[%0d]: got %b want %b", i, gnt, eg[i]);
      end
      advance(eg[i]);
      tests++;
      if (mem_en !== 1'b1 || mem_addr !== ea[i]) begin
        fails++;
        $display("FAIL rot_mem[%0d]: en %b a %h want 1 %h",
                 i, mem_en, mem_addr, ea[i]);
      end
    end
    idle(2);
  endtask

  task automatic test_write_read();
    set_port(1, 4'd5, 8'hA5);
    req = 3'b010; we = 3'b010; lock = 3'b000;
    #1;
    tests++;
    if (gnt !== 3'b010) begin
      fails++;
      $display("FAIL wr_gnt: got %b want 010", gnt);
    end
    advance(3'b010);
    tests++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 ||
        mem_addr !== 4'd5 || mem_wdata !== 8'hA5) begin
      fails++;
      $display("FAIL wr_mem: en %b we %b a %h d %h want 1 1 5 a5",
               mem_en, mem_we, mem_addr, mem_wdata);
    end
    set_port(0, 4'd5, 8'h00);
    req = 3'b001; we = 3'b000;
    #1;
    tests++;
    if (gnt !== 3'b001) begin
      fails++;
      $display("FAIL rd_gnt: got %b want 001", gnt);
    end
    advance(3'b001);
    tests++;
    if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 4'd5) begin
      fails++;
      $display("FAIL rd_mem: en %b we %b a %h want 1 0 5",
               mem_en, mem_we, mem_addr);
    end
    idle(2);
  endtask

  task automatic run_lock_seq(input string nm,
                              input logic [2:0] lk [6],
                              input logic [2:0] eg [6],
                              input logic [1:0] es [6],
                              input int n);
    set_port(0, 4'd7, 8'h00);
    set_port(1, 4'd8, 8'h00);
    set_port(2, 4'd9, 8'h00);
    we = 3'b000;
    for (int i = 0; i < n; i++) begin
      lock = lk[i];
      #1;
      tests++;
      if (cur_state !== es[i]) begin
        fails++;
        $display("FAIL %s_state[%0d]: got %b want %b",
                 nm, i, cur_state, es[i]);
      end
      tests++;
      if (gnt !== eg[i]) begin
        fails++;
        $display("FAIL %s_gnt[%0d]: got %b want %b",
                 nm, i, gnt, eg[i]);
      end
      advance(eg[i]);
    end
    tests++;
    if (cur_state !== 2'b01) begin
      fails++;
      $display("FAIL %s_end: got %b want 01", nm, cur_state);
    end
    idle(2);
  endtask

  task automatic test_lock_max();
    logic [2:0] lk [6];
    logic [2:0] eg [6];
    logic [1:0] es [6];
    lk = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010};
    eg = '{3'b010, 3'b010, 3'b010, 3'b010, 3'b100, 3'b001};
    es = '{2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01};
    req = 3'b111;
    run_lock_seq("lkmax", lk, eg, es, 6);
  endtask

  task automatic test_lock_drop();
    logic [2:0] lk [6];
    logic [2:0] eg [6];
    logic [1:0] es [6];
    lk = '{3'b010, 3'b010, 3'b000, 3'b000, 3'b000, 3'b000};
    eg = '{3'b010, 3'b010, 3'b100, 3'b001, 3'b000, 3'b000};
    es = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b01};
    req = 3'b111;
    run_lock_seq("lkdrop", lk, eg, es, 4);
  endtask

  task automatic test_lock_ignored();
    logic [2:0] rq [2];
    logic [2:0] lk [2];
    logic [2:0] eg [2];
    rq = '{3'b011, 3'b001};
    lk = '{3'b001, 3'b100};
    eg = '{3'b010, 3'b001};
    we = 3'b000;
    for (int i = 0; i < 2; i++) begin
      req = rq[i]; lock = lk[i];
      #1;
      tests++;
      if (gnt !== eg[i]) begin
        fails++;
        $display("FAIL lkign_gnt[%0d]: got %b want %b", i, gnt, eg[i]);
      end
      advance(eg[i]);
      tests++;
      if (cur_state !== 2'b01) begin
        fails++;
        $display("FAIL lkign_state[%0d]: got %b want 01", i, cur_state);
      end
    end
    idle(2);
  endtask

  task automatic test_reset_mid();
    set_port(0, 4'd7, 8'h00);
    req = 3'b001; we = 3'b000; lock = 3'b000;
    #1;
    tests++;
    if (gnt !== 3'b001) begin
      fails++;
      $display("FAIL rmid_gnt: got %b want 001", gnt);
    end
    advance(3'b001);
    reset = 1'b1; req = 3'b111;
    sb.delete();
    #1;
    tests++;
    if (gnt !== 3'b000) begin
      fails++;
      $display("FAIL rmid_gnt_rst: got %b want 000", gnt);
    end
    @(posedge clk);
    #1;
    tests++;
    if (rvalid !== 3'b000 || mem_en !== 1'b0 || cur_state !== 2'b01) begin
      fails++;
      $display("FAIL rmid_after: rv %b en %b st %b want 000 0 01",
               rvalid, mem_en, cur_state);
    end
    reset = 1'b0; req = 3'b000;
    shadow_init();
    idle(1);
    req = 3'b111;
    set_port(1, 4'd2, 8'h00);
    set_port(2, 4'd3, 8'h00);
    #1;
    tests++;
    if (gnt !== 3'b001) begin
      fails++;
      $display("FAIL rmid_rr: got %b want 001", gnt);
    end
    advance(3'b001);
    idle(2);
  endtask

`ifdef LOADER_PRIO_EN
  task automatic test_loader_prio();
    logic [2:0] rq [6];
    logic [2:0] lk [6];
    logic [2:0] eg [6];
    rq = '{3'b111, 3'b111, 3'b111, 3'b001, 3'b101, 3'b101};
    lk = '{3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b000};
    eg = '{3'b100, 3'b100, 3'b100, 3'b001, 3'b001, 3'b100};
    set_port(0, 4'd1, 8'h00);
    set_port(1, 4'd2, 8'h00);
    set_port(2, 4'd3, 8'h00);
    we = 3'b000;
    for (int i = 0; i < 6; i++) begin
      req = rq[i]; lock = lk[i];
      #1;
      tests++;
      if (gnt !== eg[i]) begin
        fails++;
        $display("FAIL prio_gnt[%0d]: got %b want %b", i, gnt, eg[i]);
      end
      advance(eg[i]);
    end
    idle(2);
  endtask
`endif

  initial begin
    shadow_init();
    test_reset();
`ifdef LOADER_PRIO_EN
    test_loader_prio();
`else
    test_rotation();
    test_write_read();
    test_lock_max();
    test_lock_drop();
    test_lock_ignored();
    test_reset_mid();
`endif
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL sb_left: %0d reads outstanding want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
